// File: rtl/leve_pkg.sv
// ---------------------------------------------------------------------------
// leve_pkg
//   Shared types and helpers for the EX-stage M-extension divide sequencer.
//   div_op_t    : divide opcode, encoded as funct3[1:0] of the instruction.
//   div_state_t : sequencer FSM state, also exported for debug visibility.
//   MIN_INT64 / MIN_INT32 : most negative integers (signed-overflow detect).
//   sext32      : sign-extend a 32-bit value to 64 bits (W-form results).
// ---------------------------------------------------------------------------
package leve_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam logic [63:0] MIN_INT64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_INT32 = 32'h8000_0000;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/leve1_div_step.sv
// ---------------------------------------------------------------------------
// leve1_div_step
//   One radix-2 restoring division step (combinational).
//   rem, quo   : current partial remainder / shifting dividend-quotient pair
//   divisor    : magnitude of the divisor
//   rem_next, quo_next : pair after shifting left one bit and trial-subtracting
// ---------------------------------------------------------------------------
module leve1_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted remainder can reach 2*divisor-1, so the trial subtraction is
  // one bit wider than the datapath; its top bit is the borrow.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  assign shifted  = {rem, quo[XLEN-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/leve1_div_seq.sv
// ---------------------------------------------------------------------------
// leve1_div_seq
//   Iterative RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU + W forms).
//   Radix-2 restoring core, one quotient bit per cycle; divide-by-zero and
//   signed overflow are resolved in the accept cycle.
//
//   Handshakes: a request transfers on a rising edge with REQ_VALID &&
//   REQ_READY; a response transfers with RSP_VALID && RSP_READY. RSP_RD is
//   held stable while RSP_VALID is high and not yet consumed.
//
//   Ports
//     CLK, RSTn            clock, asynchronous active-low reset
//     REQ_VALID/REQ_READY  request handshake (READY = IDLE && !FLUSH)
//     REQ_OP, REQ_W        opcode (funct3[1:0]) and W-form flag
//     REQ_RS1, REQ_RS2     dividend, divisor
//     FLUSH                aborts any operation, no response produced
//     BUSY                 operation in flight (state != IDLE)
//     RSP_VALID/RSP_READY  response handshake (VALID = DONE)
//     RSP_RD               quotient or remainder
//     STATE_DBG            current FSM state
// ---------------------------------------------------------------------------
module leve1_div_seq
  import leve_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  div_op_t         REQ_OP,
  input  logic            REQ_W,
  input  logic [XLEN-1:0] REQ_RS1,
  input  logic [XLEN-1:0] REQ_RS2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [XLEN-1:0] RSP_RD,
  output div_state_t      STATE_DBG
);

  div_state_t      state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  div_op_t         op_q;
  logic            w_q, neg_quo_q, neg_rem_q;

  // W results are the sign extension of the low 32 bits, for every W op.
  function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
    logic [63:0] t;
    t = sext32(v[31:0]);
    return w ? t[XLEN-1:0] : v;
  endfunction

  // ---- accept-cycle operand preparation and special-case detection ----
  logic            is_w, signed_op, a_neg, b_neg, div_zero, ovf;
  logic [63:0]     a_w64, b_w64, min64;
  logic [XLEN-1:0] a_in, b_in, min_x, abs_a, abs_b, spec_res, quo_init;

  always_comb begin
    is_w      = WORD_EN && REQ_W;
    signed_op = ~REQ_OP[0];
    a_w64     = signed_op ? sext32(REQ_RS1[31:0]) : {32'b0, REQ_RS1[31:0]};
    b_w64     = signed_op ? sext32(REQ_RS2[31:0]) : {32'b0, REQ_RS2[31:0]};
    a_in      = is_w ? a_w64[XLEN-1:0] : REQ_RS1;
    b_in      = is_w ? b_w64[XLEN-1:0] : REQ_RS2;
    min64     = (is_w || XLEN == 32) ? sext32(MIN_INT32) : MIN_INT64;
    min_x     = min64[XLEN-1:0];
    a_neg     = signed_op & a_in[XLEN-1];
    b_neg     = signed_op & b_in[XLEN-1];
    abs_a     = a_neg ? -a_in : a_in;
    abs_b     = b_neg ? -b_in : b_in;
    div_zero  = (b_in == '0);
    ovf       = signed_op && (a_in == min_x) && (&b_in);
    if (div_zero) spec_res = REQ_OP[1] ? a_in : '1;
    else          spec_res = REQ_OP[1] ? '0 : min_x;
    // A W dividend is at most 32 significant bits; park it at the top of
    // the shift register so that 32 steps consume exactly those bits.
    quo_init  = is_w ? (abs_a << (XLEN - 32)) : abs_a;
  end

  // ---- one restoring step per CALC cycle ----
  logic [XLEN-1:0] rem_nx, quo_nx;

  leve1_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // ---- sign fixup and result select ----
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    fix_res = op_q[1] ? rem_fix : quo_fix;
  end

  // ---- sequencer FSM ----
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      op_q      <= OP_DIV;
      w_q       <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      RSP_RD    <= '0;
    end else if (FLUSH) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            op_q <= REQ_OP;
            w_q  <= is_w;
            if (div_zero || ovf) begin
              RSP_RD  <= fmt(spec_res, is_w);
              state_q <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= quo_init;
              dvsr_q    <= abs_b;
              cnt_q     <= is_w ? 6'd31 : 6'(XLEN - 1);
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q == 6'd0) state_q <= FIX;
          else               cnt_q   <= cnt_q - 6'd1;
        end
        FIX: begin
          RSP_RD  <= fmt(fix_res, w_q);
          state_q <= DONE;
        end
        DONE: begin
          if (RSP_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY = (state_q == IDLE) && !FLUSH;
  assign BUSY      = (state_q != IDLE);
  assign RSP_VALID = (state_q == DONE);
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_leve1_div_seq.sv
// ---------------------------------------------------------------------------
// tb_leve1_div_seq
//   Self-checking bench for leve1_div_seq (XLEN=64, WORD_EN=1): directed
//   corner cases, hold/flush/reset scenarios and randomized operations
//   compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_leve1_div_seq;
  import leve_pkg::*;

  // ---- clock / reset ----
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        REQ_VALID, REQ_READY, REQ_W, FLUSH, BUSY, RSP_VALID, RSP_READY;
  div_op_t     REQ_OP;
  logic [63:0] REQ_RS1, REQ_RS2, RSP_RD;
  div_state_t  state_dbg;

  always #5 CLK = ~CLK;

  leve1_div_seq #(.XLEN(64), .WORD_EN(1'b1)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_W     (REQ_W),
    .REQ_RS1   (REQ_RS1),
    .REQ_RS2   (REQ_RS2),
    .FLUSH     (FLUSH),
    .BUSY      (BUSY),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RD    (RSP_RD),
    .STATE_DBG (state_dbg)
  );

  // ---- scoreboard ----
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain RISC-V M-extension arithmetic ----
  function automatic void ref_model(input logic [1:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int lat);
    if (w) begin
      int          sa, sb;
      int unsigned ua, ub;
      logic [31:0] r;
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      lat = 34;
      if (ub == 0) begin
        r = op[1] ? ua : 32'hFFFF_FFFF; lat = 1;
      end else if (!op[0] && sa == int'(32'h8000_0000) && sb == -1) begin
        r = op[1] ? 32'h0 : 32'h8000_0000; lat = 1;
      end else begin
        case (op)
          2'd0:    r = sa / sb;
          2'd1:    r = ua / ub;
          2'd2:    r = sa % sb;
          default: r = ua % ub;
        endcase
      end
      res = {{32{r[31]}}, r};
    end else begin
      longint          sa, sb;
      longint unsigned ua, ub;
      sa = a; sb = b; ua = a; ub = b;
      lat = 66;
      if (ub == 0) begin
        res = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF; lat = 1;
      end else if (!op[0] && sa == longint'(64'h8000_0000_0000_0000) && sb == -1) begin
        res = op[1] ? 64'h0 : 64'h8000_0000_0000_0000; lat = 1;
      end else begin
        case (op)
          2'd0:    res = sa / sb;
          2'd1:    res = ua / ub;
          2'd2:    res = sa % sb;
          default: res = ua % ub;
        endcase
      end
    end
  endfunction

  // ---- driver tasks ----
  // Waits for the response of an already accepted op. Latency counts rising
  // edges from the accept edge (inclusive) to the first edge after which
  // RSP_VALID is high.
  task automatic wait_rsp(input int lat_exp, input int hold);
    int          lat;
    logic [63:0] e;
    lat = 1;
    while (!RSP_VALID && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check("rsp_valid", RSP_VALID, 1'b1);
    check("rsp_rd", RSP_RD, e);
    check("latency", lat, lat_exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_rd", RSP_RD, e);
      check("hold_valid", RSP_VALID, 1'b1);
      check("hold_req_ready", REQ_READY, 1'b0);
      check("hold_busy", BUSY, 1'b1);
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("idle_busy", BUSY, 1'b0);
    check("idle_valid", RSP_VALID, 1'b0);
  endtask

  task automatic issue(input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge CLK);
    REQ_OP = div_op_t'(op); REQ_W = w; REQ_RS1 = a; REQ_RS2 = b;
    REQ_VALID = 1'b1;
    #1 check("req_ready", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat_exp, input int hold);
    exp_q.push_back(exp);
    issue(op, w, a, b);
    wait_rsp(lat_exp, hold);
  endtask

  // ---- stimulus ----
  initial begin
    logic [63:0] a, b, r;
    logic [1:0]  op;
    logic        w;
    int          lat;

    RSTn = 1'b0; REQ_VALID = 1'b0; REQ_OP = OP_DIV; REQ_W = 1'b0;
    REQ_RS1 = '0; REQ_RS2 = '0; FLUSH = 1'b0; RSP_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", REQ_READY, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_rsp_rd", RSP_RD, 64'h0);
    check("rst_state", state_dbg, IDLE);
    @(negedge CLK);
    RSTn = 1'b1;

    // directed cases
    run_op(2'd0, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0);
    run_op(2'd2, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op(2'd3, 1'b0, 64'd20, 64'd3, 64'd2, 66, 0);
    run_op(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66, 0);
    run_op(2'd1, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op(2'd3, 1'b0, 64'd7, 64'd0, 64'd7, 1, 0);
    run_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1, 0);
    run_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h0, 1, 0);
    run_op(2'd0, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34, 0);
    run_op(2'd1, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34, 0);
    run_op(2'd0, 1'b0, 64'd0, 64'd1, 64'd0, 66, 0);
    run_op(2'd1, 1'b0, 64'd3, 64'd5, 64'd0, 66, 0);
    run_op(2'd0, 1'b0, 64'd12345, 64'd1, 64'd12345, 66, 0);
    run_op(2'd3, 1'b1, 64'hDEAD_BEEF_0000_0007, 64'd0, 64'd7, 1, 0);

    // response held off for 5 cycles
    run_op(2'd0, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 5);

    // flush at CALC cycle 10, with a same-cycle request that must be refused
    issue(2'd1, 1'b0, 64'd1000, 64'd7);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    check("calc_busy", BUSY, 1'b1);
    FLUSH = 1'b1;
    REQ_OP = OP_DIVU; REQ_W = 1'b0; REQ_RS1 = 64'd100; REQ_RS2 = 64'd9;
    REQ_VALID = 1'b1;
    #1 check("flush_req_ready_calc", REQ_READY, 1'b0);
    @(posedge CLK); #1;
    check("flush_busy", BUSY, 1'b0);
    check("flush_rsp_valid", RSP_VALID, 1'b0);
    check("flush_req_ready_idle", REQ_READY, 1'b0);
    @(posedge CLK); #1;
    check("flush_not_accepted", BUSY, 1'b0);
    check("flush_no_rsp", RSP_VALID, 1'b0);
    @(negedge CLK);
    FLUSH = 1'b0;
    exp_q.push_back(64'd11);
    #1 check("post_flush_req_ready", REQ_READY, 1'b1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("post_flush_accept", BUSY, 1'b1);
    wait_rsp(66, 0);

    // asynchronous reset in the middle of CALC
    issue(2'd1, 1'b0, 64'd123456, 64'd7);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("arst_req_ready", REQ_READY, 1'b1);
    check("arst_busy", BUSY, 1'b0);
    check("arst_rsp_valid", RSP_VALID, 1'b0);
    check("arst_rsp_rd", RSP_RD, 64'h0);
    @(negedge CLK);
    RSTn = 1'b1;

    // randomized operations against the reference model
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ;
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        2: b = w ? {$urandom, 32'h0} : 64'h0;
        3: begin
             a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
             b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
           end
        4: b = -64'($urandom_range(1, 9));
        default: begin a = -64'($urandom_range(1, 5000)); b = 64'($urandom_range(1, 300)); end
      endcase
      ref_model(op, w, a, b, r, lat);
      run_op(op, w, a, b, r, lat, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
